// File: rtl/mem_dump_pkg.sv
// Shared types and defaults for the memory dump controller.
package mem_dump_pkg;

  localparam int ADDR_W_DEF = 16;

  // Encodings 3'd4..3'd7 are never entered; they fall back to IDLE.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_HOLD = 3'd2,
    ST_DONE = 3'd3,
    ST_RSVD = 3'd4
  } state_e;

endpackage

// File: rtl/mem_dump_ctrl_if.sv
// Control and memory-read signals of the dump controller.
interface mem_dump_ctrl_if
  import mem_dump_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
);
  logic              start;
  logic              stop;
  logic              step;
  logic              auto;
  logic [ADDR_W-1:0] first_addr;
  logic [ADDR_W-1:0] last_addr;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack;
  logic              busy;
  logic              done;

  modport master (
    output start, stop, step, auto, first_addr, last_addr, rd_ack,
    input  rd_req, rd_addr, busy, done
  );

  modport slave (
    input  start, stop, step, auto, first_addr, last_addr, rd_ack,
    output rd_req, rd_addr, busy, done
  );
endinterface

// File: rtl/dwell_timer.sv
// Hold-time counter for auto-advance; expire_o flags the last cycle of the dwell.
module dwell_timer #(
  parameter int DWELL = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);
  localparam int CNT_W = $clog2(DWELL);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (enable_i) begin
      if (cnt_q == CNT_LAST) cnt_q <= '0;
      else                   cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign expire_o = enable_i && (cnt_q == CNT_LAST);
endmodule

// File: rtl/mem_dump_ctrl.sv
// Walks an address range issuing memory reads, advancing on step or (with
// MEM_DUMP_AUTO_EN defined) after a fixed dwell time in auto mode.
module mem_dump_ctrl
  import mem_dump_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DWELL  = 50_000_000
) (
  input logic           clk,
  input logic           reset,
  mem_dump_ctrl_if.slave bus
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] first_q, last_q;
  logic              rd_req_q, busy_q, done_q;
  logic              expire_s;
  logic              advance_s;

`ifdef MEM_DUMP_AUTO_EN
  dwell_timer #(.DWELL(DWELL)) u_dwell (
    .clk      (clk),
    .reset    (reset),
    .clear_i  ((state_q != ST_HOLD) || !bus.auto),
    .enable_i ((state_q == ST_HOLD) && bus.auto),
    .expire_o (expire_s)
  );
`else
  logic unused_cfg_s;
  assign unused_cfg_s = bus.auto ^ DWELL[0];
  assign expire_s     = 1'b0;
`endif

  // A coincident step and dwell expiry collapse into a single advance.
  assign advance_s = bus.step || expire_s;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_REQ;
          addr_d  = bus.first_addr;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (bus.stop)        state_d = ST_IDLE;
        else if (bus.rd_ack) state_d = ST_HOLD;
        else                 state_d = ST_REQ;
      end
      ST_HOLD: begin
        if (bus.stop) begin
          state_d = ST_IDLE;
        end else if (advance_s) begin
          if (addr_q == last_q) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_REQ;
            addr_d  = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
          end
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      first_q  <= '0;
      last_q   <= '0;
      rd_req_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      if (state_q == ST_IDLE && bus.start) begin
        first_q <= bus.first_addr;
        last_q  <= bus.last_addr;
      end else begin
        first_q <= first_q;
        last_q  <= last_q;
      end
      rd_req_q <= (state_d == ST_REQ);
      busy_q   <= (state_d != ST_IDLE);
      done_q   <= (state_d == ST_DONE);
    end
  end

  assign bus.rd_req  = rd_req_q;
  assign bus.rd_addr = addr_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
endmodule

// File: tb/tb_mem_dump_ctrl.sv
// Directed bench for mem_dump_ctrl with a queue-based reference model.
module tb_mem_dump_ctrl;
  localparam int AW = 16;
  localparam int DW = 4;
`ifdef MEM_DUMP_AUTO_EN
  localparam bit AUTO_EN = 1'b1;
`else
  localparam bit AUTO_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int checks   = 0;
  int failures = 0;

  mem_dump_ctrl_if #(.ADDR_W(AW)) bus ();
  mem_dump_ctrl #(.ADDR_W(AW), .DWELL(DW)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 reading, 2 holding, 3 finished; pending addresses in a queue.
  int          m_phase = 0;
  logic [15:0] m_addr  = 16'h0000;
  logic [15:0] m_q[$];
  int          m_hold  = 0;

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_phase = 0; m_addr = 16'h0000; m_q.delete(); m_hold = 0;
    end else if (m_phase == 0) begin
      if (bus.start) begin
        int n;
        n = int'((bus.last_addr - bus.first_addr) & 16'hFFFF);
        m_q.delete();
        for (int i = 0; i <= n; i++) m_q.push_back(16'(bus.first_addr + i));
        m_addr  = m_q.pop_front();
        m_phase = 1;
      end
    end else if (bus.stop) begin
      m_phase = 0;
    end else if (m_phase == 1) begin
      if (bus.rd_ack) begin m_phase = 2; m_hold = 0; end
    end else if (m_phase == 2) begin
      bit adv;
      adv = bus.step || (AUTO_EN && bus.auto && m_hold == DW - 1);
      m_hold = (AUTO_EN && bus.auto) ? m_hold + 1 : 0;
      if (adv) begin
        if (m_q.size() == 0) m_phase = 3;
        else begin m_addr = m_q.pop_front(); m_phase = 1; end
      end
    end else begin
      m_phase = 0;
    end
  end

  // Every-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    check("rd_req",  {31'd0, bus.rd_req}, {31'd0, m_phase == 1});
    check("busy",    {31'd0, bus.busy},   {31'd0, m_phase != 0});
    check("done",    {31'd0, bus.done},   {31'd0, m_phase == 3});
    check("rd_addr", {16'd0, bus.rd_addr}, {16'd0, m_addr});
  end

  // Memory: ack arrives one cycle after rd_req rises.
  logic ack_pend = 1'b0;
  initial begin
    bus.rd_ack = 1'b0;
    forever begin
      @(negedge clk);
      bus.rd_ack = ack_pend && bus.rd_req;
      ack_pend   = bus.rd_req && !bus.rd_ack;
    end
  end

  logic [15:0] log_q[$];
  logic [15:0] exp_q[$];
  logic        mon_prev = 1'b0;
  int          done_cnt = 0;
  int          hold_cyc = 0;

  initial forever begin
    @(negedge clk);
    if (bus.rd_req && !mon_prev) log_q.push_back(bus.rd_addr);
    mon_prev = bus.rd_req;
    if (bus.done) done_cnt++;
    if (bus.busy && !bus.rd_req && !bus.done) hold_cyc++;
  end

  task automatic clear_log();
    log_q.delete(); done_cnt = 0; hold_cyc = 0;
  endtask

  task automatic check_log(input string name);
    check({name, "_len"}, 32'(log_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < log_q.size()) check({name, "_addr"}, {16'd0, log_q[i]}, {16'd0, exp_q[i]});
  endtask

  task automatic start_dump(input logic [15:0] f, input logic [15:0] l);
    bus.first_addr = f; bus.last_addr = l; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic pulse_step();
    bus.step = 1'b1;
    @(negedge clk);
    bus.step = 1'b0;
  endtask

  task automatic wait_hold();
    int n = 0;
    while (!(bus.busy && !bus.rd_req && !bus.done) && n < 20) begin @(negedge clk); n++; end
    check("hold_timeout", {31'd0, n >= 20}, 32'd0);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (bus.busy && n < budget) begin @(negedge clk); n++; end
    check("idle_timeout", {31'd0, n >= budget}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.start = 1'b0; bus.stop = 1'b0; bus.step = 1'b0; bus.auto = 1'b0;
    bus.first_addr = 16'h0000; bus.last_addr = 16'h0000;
    repeat (2) @(negedge clk);
    check("rst_rd_req", {31'd0, bus.rd_req}, 32'd0);
    check("rst_busy",   {31'd0, bus.busy},   32'd0);
    check("rst_done",   {31'd0, bus.done},   32'd0);
    check("rst_addr",   {16'd0, bus.rd_addr}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Manual three-address dump.
    clear_log();
    start_dump(16'h0010, 16'h0012);
    repeat (3) begin wait_hold(); pulse_step(); end
    wait_idle(40);
    exp_q = {16'h0010, 16'h0011, 16'h0012};
    check_log("manual");
    check("manual_done", 32'(done_cnt), 32'd1);
    check("manual_busy", {31'd0, bus.busy}, 32'd0);

    // Wrap through the top of the address space.
    clear_log();
    start_dump(16'hFFFE, 16'h0001);
    repeat (4) begin wait_hold(); pulse_step(); end
    wait_idle(40);
    exp_q = {16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    check_log("wrap");
    check("wrap_done", 32'(done_cnt), 32'd1);

    // Abort while reading 0x0011, with stop coinciding with rd_ack.
    clear_log();
    start_dump(16'h0010, 16'h0012);
    wait_hold(); pulse_step();
    @(negedge clk);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    check("abort_rd_req", {31'd0, bus.rd_req}, 32'd0);
    check("abort_busy",   {31'd0, bus.busy},   32'd0);
    repeat (4) @(negedge clk);
    exp_q = {16'h0010, 16'h0011};
    check_log("abort");
    check("abort_done", 32'(done_cnt), 32'd0);
    clear_log();
    start_dump(16'h0020, 16'h0020);
    wait_hold(); pulse_step();
    wait_idle(40);
    exp_q = {16'h0020};
    check_log("restart");
    check("restart_done", 32'(done_cnt), 32'd1);

    // Step during REQ and start while busy are both ignored.
    clear_log();
    start_dump(16'h0030, 16'h0031);
    pulse_step();
    wait_hold();
    start_dump(16'h0099, 16'h0099);
    wait_hold(); pulse_step();
    wait_hold(); pulse_step();
    wait_idle(40);
    exp_q = {16'h0030, 16'h0031};
    check_log("ignore");
    check("ignore_done", 32'(done_cnt), 32'd1);

    // Asynchronous reset in the middle of a hold.
    start_dump(16'h0060, 16'h0062);
    wait_hold();
    #2 reset = 1'b1;
    #1;
    check("arst_rd_req", {31'd0, bus.rd_req}, 32'd0);
    check("arst_busy",   {31'd0, bus.busy},   32'd0);
    check("arst_done",   {31'd0, bus.done},   32'd0);
    check("arst_addr",   {16'd0, bus.rd_addr}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    clear_log();
    start_dump(16'h0070, 16'h0070);
    wait_hold(); pulse_step();
    wait_idle(40);
    exp_q = {16'h0070};
    check_log("post_reset");
    check("post_reset_done", 32'(done_cnt), 32'd1);

`ifdef MEM_DUMP_AUTO_EN
    // Timed auto-advance, then a step landing on the expiry cycle.
    bus.auto = 1'b1;
    clear_log();
    start_dump(16'h0000, 16'h0002);
    wait_idle(80);
    exp_q = {16'h0000, 16'h0001, 16'h0002};
    check_log("auto");
    check("auto_hold_cycles", 32'(hold_cyc), 32'd12);
    check("auto_done", 32'(done_cnt), 32'd1);
    clear_log();
    start_dump(16'h0050, 16'h0052);
    wait_hold();
    repeat (3) @(negedge clk);
    pulse_step();
    wait_idle(80);
    exp_q = {16'h0050, 16'h0051, 16'h0052};
    check_log("coincide");
    check("coincide_done", 32'(done_cnt), 32'd1);
    bus.auto = 1'b0;
`else
    // auto has no effect without the timer: HOLD waits for step.
    bus.auto = 1'b1;
    clear_log();
    start_dump(16'h0080, 16'h0081);
    wait_hold();
    repeat (12) @(negedge clk);
    check("noauto_busy",   {31'd0, bus.busy},   32'd1);
    check("noauto_rd_req", {31'd0, bus.rd_req}, 32'd0);
    check("noauto_addr",   {16'd0, bus.rd_addr}, 32'h0080);
    pulse_step();
    wait_hold(); pulse_step();
    wait_idle(40);
    exp_q = {16'h0080, 16'h0081};
    check_log("noauto");
    check("noauto_done", 32'(done_cnt), 32'd1);
    bus.auto = 1'b0;
`endif

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
